// File: rtl/periph_pkg.sv
// Shared constants for the peripheral responder: window base, register offsets
// and the hex-to-seven-segment table.
package periph_pkg;

    localparam logic [19:0] PERIPH_BASE = 20'hFFFFF;

    localparam logic [11:0] OFF_DIG  = 12'h000;
    localparam logic [11:0] OFF_TCNT = 12'h020;
    localparam logic [11:0] OFF_TDIV = 12'h024;
    localparam logic [11:0] OFF_LED  = 12'h060;
    localparam logic [11:0] OFF_SW   = 12'h070;
    localparam logic [11:0] OFF_BTN  = 12'h078;

    // Active-high segments, bit order {G,F,E,D,C,B,A}.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bus_periph_resp_if.sv
// CPU data bus as seen by the peripheral responder.
// No handshake: the CPU presents Bus_addr/Bus_we/Bus_wdata for one cycle, a write
// commits at the closing clock edge, and Bus_rdata/periph_hit are combinational.
interface bus_periph_resp_if;
    logic [31:0] Bus_addr;
    logic        Bus_we;
    logic [31:0] Bus_wdata;
    logic [31:0] Bus_rdata;
    logic        periph_hit;

    modport master (output Bus_addr, Bus_we, Bus_wdata, input Bus_rdata, periph_hit);
    modport slave  (input Bus_addr, Bus_we, Bus_wdata, output Bus_rdata, periph_hit);
endinterface

// File: rtl/bus_periph_resp_seg_scan.sv
// Multiplexed 8-digit seven-segment driver: each digit is lit for SCAN_DIV cycles in turn.
module seg_scan
    import periph_pkg::*;
#(
    parameter int SCAN_DIV = 20000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] digits,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);

    localparam int SC_W = $clog2(SCAN_DIV);

    logic [SC_W-1:0] sc_q, sc_d;
    logic [2:0]      idx_q, idx_d;

    always_comb begin
        sc_d  = sc_q + SC_W'(1);
        idx_d = idx_q;
        if (sc_q == SC_W'(SCAN_DIV - 1)) begin
            sc_d  = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            sc_q  <= '0;
            idx_q <= '0;
        end else begin
            sc_q  <= sc_d;
            idx_q <= idx_d;
        end
    end

    // Decode straight from the live digit register so a DIG write shows next cycle.
    assign dig_en  = ~(8'b1 << idx_q);
    assign dig_seg = {1'b1, ~hex7(digits[{idx_q, 2'b00} +: 4])};

endmodule

// File: rtl/bus_periph_resp.sv
// Peripheral-window responder: LED, display and timer registers plus switch/button
// synchronisers, with combinational reads and write-on-edge.
module bus_periph_resp
    import periph_pkg::*;
#(
    parameter int SCAN_DIV = 20000,
    parameter int TIMER_W  = 32
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rst,
    bus_periph_resp_if.slave       bus,
    input  logic [23:0]            sw,
    input  logic [4:0]             button,
    output logic [23:0]            led,
    output logic [7:0]             dig_en,
    output logic [7:0]             dig_seg
);

    logic [31:0]        dig_q, dig_d;
    logic [TIMER_W-1:0] tcnt_q, tcnt_d;
    logic [TIMER_W-1:0] tdiv_q, tdiv_d;
    logic [TIMER_W-1:0] pre_q, pre_d;
    logic [23:0]        led_q, led_d;
    logic [23:0]        sw_meta_q, sw_sync_q;
    logic [4:0]         btn_meta_q, btn_sync_q;

    logic        hit;
    logic        wr;
    logic [11:0] off;
    logic [31:0] rdata;
    logic        unused_addr_lsb;

    assign hit             = (bus.Bus_addr[31:12] == PERIPH_BASE);
    assign off             = {bus.Bus_addr[11:2], 2'b00};
    assign wr              = bus.Bus_we && hit;
    assign unused_addr_lsb = ^bus.Bus_addr[1:0];

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                OFF_DIG:  rdata = dig_q;
                OFF_TCNT: rdata = 32'(tcnt_q);
                OFF_TDIV: rdata = 32'(tdiv_q);
                OFF_LED:  rdata = {8'h00, led_q};
                OFF_SW:   rdata = {8'h00, sw_sync_q};
                OFF_BTN:  rdata = {27'h0, btn_sync_q};
                default:  rdata = '0;
            endcase
        end
    end

    always_comb begin
        dig_d  = dig_q;
        led_d  = led_q;
        tdiv_d = tdiv_q;
        tcnt_d = tcnt_q;
        pre_d  = pre_q;
        if (tdiv_q != '0) begin
            if (pre_q == tdiv_q - TIMER_W'(1)) begin
                pre_d  = '0;
                tcnt_d = tcnt_q + TIMER_W'(1);
            end else begin
                pre_d = pre_q + TIMER_W'(1);
            end
        end
        // Bus writes come last so they override a same-cycle tick.
        if (wr) begin
            case (off)
                OFF_DIG:  dig_d = bus.Bus_wdata;
                OFF_LED:  led_d = bus.Bus_wdata[23:0];
                OFF_TCNT: begin
                    tcnt_d = bus.Bus_wdata[TIMER_W-1:0];
                    pre_d  = '0;
                end
                OFF_TDIV: begin
                    tdiv_d = bus.Bus_wdata[TIMER_W-1:0];
                    pre_d  = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            dig_q      <= '0;
            tcnt_q     <= '0;
            tdiv_q     <= '0;
            pre_q      <= '0;
            led_q      <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            dig_q      <= dig_d;
            tcnt_q     <= tcnt_d;
            tdiv_q     <= tdiv_d;
            pre_q      <= pre_d;
            led_q      <= led_d;
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= button;
            btn_sync_q <= btn_meta_q;
        end
    end

    assign bus.Bus_rdata  = rdata;
    assign bus.periph_hit = hit;
    assign led            = led_q;

    seg_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .digits  (dig_q),
        .dig_en  (dig_en),
        .dig_seg (dig_seg)
    );

endmodule
